// File: rtl/datapath_pkg.sv
// Shared encodings for the datapath sequencer: instruction fields, opcodes,
// function-select codes, FSM states and the decoder output bundle.
package datapath_pkg;

  localparam int INSTR_W = 16;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int D_HI   = 11;
  localparam int D_LO   = 9;
  localparam int A_HI   = 8;
  localparam int A_LO   = 6;
  localparam int B_HI   = 5;
  localparam int B_LO   = 3;
  localparam int IMM_HI = 2;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Function-unit codes mirror the opcode for 1..8; LDI uses the B pass-through.
  localparam logic [3:0] FS_ZERO  = 4'h0;
  localparam logic [3:0] FS_MOVA  = 4'h1;
  localparam logic [3:0] FS_ADD   = 4'h2;
  localparam logic [3:0] FS_SUB   = 4'h3;
  localparam logic [3:0] FS_AND   = 4'h4;
  localparam logic [3:0] FS_OR    = 4'h5;
  localparam logic [3:0] FS_XOR   = 4'h6;
  localparam logic [3:0] FS_NOT   = 4'h7;
  localparam logic [3:0] FS_ADDI  = 4'h8;
  localparam logic [3:0] FS_PASSB = 4'h9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB,
    ST_HALTED
  } state_t;

  typedef struct packed {
    logic [3:0] fs;
    logic       mb;
    logic       writes_reg;
    logic       is_halt;
    logic       is_nop;
  } decode_t;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Instruction handshake between the instruction source and the sequencer.
interface datapath_sequencer_if
  import datapath_pkg::*;
#(
  parameter int DW = INSTR_W
);
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/sequencer_decode.sv
// Combinational opcode decoder; illegal opcodes 10..14 decode as NOP.
module sequencer_decode
  import datapath_pkg::*;
(
  input  logic [3:0] opcode,
  output decode_t    dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        dec.fs         = opcode;
        dec.writes_reg = 1'b1;
      end
      OP_ADDI: begin
        dec.fs         = FS_ADDI;
        dec.mb         = 1'b1;
        dec.writes_reg = 1'b1;
      end
      OP_LDI: begin
        dec.fs         = FS_PASSB;
        dec.mb         = 1'b1;
        dec.writes_reg = 1'b1;
      end
      OP_HALT: dec.is_halt = 1'b1;
      default: dec.is_nop  = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle READ/EXEC/WB controller driving register-file addresses,
// write enable and function-unit controls from a captured instruction.
module datapath_sequencer
  import datapath_pkg::*;
#(
  parameter int AW   = 3,
  parameter int DW   = 16,
  parameter int FSW  = 4,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  datapath_sequencer_if.slave  ibus,
  input  logic                 resume,
  output logic [AW-1:0]        AAddress,
  output logic [AW-1:0]        BAddress,
  output logic [AW-1:0]        DAddress,
  output logic                 ReadOrWrite,
  output logic [FSW-1:0]       FS,
  output logic                 MB,
  output logic [DW-1:0]        ConstantIn,
  output logic                 busy,
  output logic                 halted,
  output logic [CNTW-1:0]      retired
);

  state_t          state_reg, state_next;
  decode_t         dec_in;
  logic            transfer;
  logic [AW-1:0]   a_reg, b_reg, d_reg;
  logic [2:0]      imm_reg;
  logic [FSW-1:0]  fs_reg;
  logic            mb_reg, wr_reg, row_reg;
  logic [CNTW-1:0] retired_reg;

  sequencer_decode u_decode (
    .opcode (ibus.instr[OPC_HI:OPC_LO]),
    .dec    (dec_in)
  );

  assign ibus.instr_ready = (state_reg == ST_IDLE);
  assign transfer         = ibus.instr_valid && ibus.instr_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (transfer) begin
          if (dec_in.is_halt)     state_next = ST_HALTED;
          else if (dec_in.is_nop) state_next = ST_IDLE;
          else                    state_next = ST_READ;
        end
      end
      ST_READ:   state_next = ST_EXEC;
      ST_EXEC:   state_next = ST_WB;
      ST_WB:     state_next = ST_IDLE;
      ST_HALTED: if (resume) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Controls are captured only on transfer, so they never move while the
  // write enable is open; the write enable itself is a clean flop output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      d_reg       <= '0;
      imm_reg     <= '0;
      fs_reg      <= '0;
      mb_reg      <= 1'b0;
      wr_reg      <= 1'b0;
      row_reg     <= 1'b0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (transfer) begin
        d_reg   <= AW'(ibus.instr[D_HI:D_LO]);
        a_reg   <= AW'(ibus.instr[A_HI:A_LO]);
        b_reg   <= AW'(ibus.instr[B_HI:B_LO]);
        imm_reg <= ibus.instr[IMM_HI:IMM_LO];
        fs_reg  <= FSW'(dec_in.fs);
        mb_reg  <= dec_in.mb;
        wr_reg  <= dec_in.writes_reg;
      end
      row_reg <= (state_next == ST_WB) && wr_reg;
      if (state_reg == ST_WB) retired_reg <= retired_reg + CNTW'(1);
    end
  end

  assign AAddress    = a_reg;
  assign BAddress    = b_reg;
  assign DAddress    = d_reg;
  assign ReadOrWrite = row_reg;
  assign FS          = fs_reg;
  assign MB          = mb_reg;
  assign ConstantIn  = DW'(imm_reg);
  assign busy        = (state_reg == ST_READ) || (state_reg == ST_EXEC) || (state_reg == ST_WB);
  assign halted      = (state_reg == ST_HALTED);
  assign retired     = retired_reg;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with a behavioural register file and
// function unit attached; a narrow-counter instance exercises retired wrap.
module tb_datapath_sequencer;
  import datapath_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic resume = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  datapath_sequencer_if #(.DW(16)) ibus ();
  logic [2:0]  AAddress, BAddress, DAddress;
  logic        ReadOrWrite, MB, busy, halted;
  logic [3:0]  FS;
  logic [15:0] ConstantIn, retired;

  datapath_sequencer #(.AW(3), .DW(16), .FSW(4), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .ibus(ibus), .resume(resume),
    .AAddress(AAddress), .BAddress(BAddress), .DAddress(DAddress),
    .ReadOrWrite(ReadOrWrite), .FS(FS), .MB(MB), .ConstantIn(ConstantIn),
    .busy(busy), .halted(halted), .retired(retired)
  );

  datapath_sequencer_if #(.DW(16)) ibus2 ();
  logic [2:0]  a_w, b_w, d_w;
  logic        row_w, mb_w, busy_w, halted_w;
  logic [3:0]  fs_w;
  logic [15:0] const_w;
  logic [1:0]  retired_w;

  datapath_sequencer #(.AW(3), .DW(16), .FSW(4), .CNTW(2)) dut_w (
    .clk(clk), .rst(rst), .ibus(ibus2), .resume(1'b0),
    .AAddress(a_w), .BAddress(b_w), .DAddress(d_w),
    .ReadOrWrite(row_w), .FS(fs_w), .MB(mb_w), .ConstantIn(const_w),
    .busy(busy_w), .halted(halted_w), .retired(retired_w)
  );

  // Register file and function unit model sitting on the datapath side
  logic [15:0] rf [8] = '{default: 16'h0000};

  function automatic logic [15:0] fu(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    case (f)
      4'h1: return a;
      4'h2: return a + b;
      4'h3: return a - b;
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return a ^ b;
      4'h7: return ~a;
      4'h8: return a + b;
      4'h9: return b;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk)
    if (ReadOrWrite) rf[DAddress] <= fu(FS, rf[AAddress], MB ? ConstantIn : rf[BAddress]);

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] d, input logic [2:0] a,
                                     input logic [2:0] b, input logic [2:0] imm);
    return {op, d, a, b, imm};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    int n;
    ibus.instr = w;
    ibus.instr_valid = 1'b1;
    n = 0;
    while (!ibus.instr_ready && n < 50) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 50) begin
      miscompares++;
      $display("FAIL send_timeout instr=%h instr_ready=%b required 1", w, ibus.instr_ready);
    end
    tick();
    ibus.instr_valid = 1'b0;
    $display("send instr=%h", w);
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 50) begin
      miscompares++;
      $display("FAIL idle_timeout busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ibus.instr = 16'h0000;
    ibus.instr_valid = 1'b0;
    ibus2.instr = 16'h0000;
    ibus2.instr_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({AAddress, BAddress, DAddress} !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_addr got=%h required 0", {AAddress, BAddress, DAddress});
    end
    vectors++;
    if ({ReadOrWrite, FS, MB, ConstantIn} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl row=%b fs=%h mb=%b const=%h required all 0", ReadOrWrite, FS, MB, ConstantIn);
    end
    vectors++;
    if (busy !== 1'b0 || halted !== 1'b0 || retired !== 16'd0 || ibus.instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_status busy=%b halted=%b retired=%0d ready=%b required 0 0 0 1",
               busy, halted, retired, ibus.instr_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_ldi_sequence;
    logic [15:0] words [2];
    logic [2:0]  exp_d [2];
    logic [2:0]  row_seen;
    logic [2:0]  d_seen;
    words[0] = mk(OP_LDI, 3'd1, 3'd0, 3'd0, 3'd5);
    words[1] = mk(OP_ADD, 3'd2, 3'd1, 3'd1, 3'd0);
    exp_d[0] = 3'd1;
    exp_d[1] = 3'd2;
    for (int i = 0; i < 2; i++) begin
      send(words[i]);
      d_seen = 3'd0;
      for (int c = 0; c < 3; c++) begin
        row_seen[c] = ReadOrWrite;
        if (c == 2) d_seen = DAddress;
        tick();
      end
      vectors++;
      if (row_seen !== 3'b100) begin
        miscompares++;
        $display("FAIL ldi_row_pulse instr=%0d read/exec/wb=%b required 100", i, row_seen);
      end
      vectors++;
      if (d_seen !== exp_d[i]) begin
        miscompares++;
        $display("FAIL ldi_daddr instr=%0d got=%0d required %0d", i, d_seen, exp_d[i]);
      end
      vectors++;
      if (ReadOrWrite !== 1'b0 || ibus.instr_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL ldi_after_wb row=%b ready=%b required 0 1", ReadOrWrite, ibus.instr_ready);
      end
    end
    vectors++;
    if (rf[2] !== 16'd10 || retired !== 16'd2) begin
      miscompares++;
      $display("FAIL ldi_result r2=%0d retired=%0d required 10 2", rf[2], retired);
    end
    $display("test_ldi_sequence r1=%0d r2=%0d retired=%0d", rf[1], rf[2], retired);
  endtask

  task automatic test_back_to_back;
    logic [15:0] words [3];
    int          got [3];
    int          k;
    logic        xfer, changed, exp_changed;
    logic [2:0]  prev_a, prev_b;
    words[0] = mk(OP_ADD, 3'd5, 3'd2, 3'd1, 3'd0);
    words[1] = mk(OP_ADD, 3'd6, 3'd1, 3'd2, 3'd0);
    words[2] = mk(OP_ADD, 3'd7, 3'd3, 3'd3, 3'd0);
    got = '{-1, -1, -1};
    k = 0;
    ibus.instr = words[0];
    ibus.instr_valid = 1'b1;
    prev_a = AAddress;
    prev_b = BAddress;
    for (int c = 0; c < 12; c++) begin
      xfer = ibus.instr_ready && ibus.instr_valid;
      tick();
      if (xfer && k < 3) begin
        got[k] = c;
        k++;
        if (k < 3) ibus.instr = words[k];
        else       ibus.instr_valid = 1'b0;
      end
      changed = (AAddress !== prev_a) || (BAddress !== prev_b);
      exp_changed = (c == 0) || (c == 4) || (c == 8);
      vectors++;
      if (changed !== exp_changed) begin
        miscompares++;
        $display("FAIL b2b_addr_change after_edge=%0d changed=%b required %b", c, changed, exp_changed);
      end
      prev_a = AAddress;
      prev_b = BAddress;
    end
    vectors++;
    if (k != 3 || got[0] != 0 || got[1] != 4 || got[2] != 8) begin
      miscompares++;
      $display("FAIL b2b_transfers count=%0d cycles=%0d,%0d,%0d required 3 at 0,4,8", k, got[0], got[1], got[2]);
    end
    vectors++;
    if (rf[5] !== 16'd15 || rf[6] !== 16'd15 || rf[7] !== 16'd0 || retired !== 16'd5) begin
      miscompares++;
      $display("FAIL b2b_result r5=%0d r6=%0d r7=%0d retired=%0d required 15 15 0 5",
               rf[5], rf[6], rf[7], retired);
    end
    $display("test_back_to_back transfers=%0d,%0d,%0d retired=%0d", got[0], got[1], got[2], retired);
  endtask

  task automatic test_nop_illegal;
    logic [3:0] ops [2];
    logic       row_any;
    ops[0] = OP_NOP;
    ops[1] = 4'hB;
    for (int i = 0; i < 2; i++) begin
      send(mk(ops[i], 3'd1, 3'd2, 3'd3, 3'd4));
      vectors++;
      if (ibus.instr_ready !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL nop_ready op=%h ready=%b busy=%b required 1 0", ops[i], ibus.instr_ready, busy);
      end
      row_any = 1'b0;
      for (int c = 0; c < 4; c++) begin
        row_any = row_any | ReadOrWrite;
        tick();
      end
      vectors++;
      if (row_any !== 1'b0 || retired !== 16'd5 || rf[1] !== 16'd5) begin
        miscompares++;
        $display("FAIL nop_effect op=%h row_seen=%b retired=%0d r1=%0d required 0 5 5",
                 ops[i], row_any, retired, rf[1]);
      end
    end
    $display("test_nop_illegal retired=%0d", retired);
  endtask

  task automatic test_halt_resume;
    send(mk(OP_HALT, 3'd0, 3'd0, 3'd0, 3'd0));
    vectors++;
    if (halted !== 1'b1 || ibus.instr_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_enter halted=%b ready=%b busy=%b required 1 0 0", halted, ibus.instr_ready, busy);
    end
    ibus.instr = mk(OP_SUB, 3'd3, 3'd2, 3'd1, 3'd0);
    ibus.instr_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (ibus.instr_ready !== 1'b0 || halted !== 1'b1) begin
        miscompares++;
        $display("FAIL halt_hold cycle=%0d ready=%b halted=%b required 0 1", c, ibus.instr_ready, halted);
      end
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    vectors++;
    if (halted !== 1'b0 || ibus.instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_resume halted=%b ready=%b required 0 1", halted, ibus.instr_ready);
    end
    tick();
    ibus.instr_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_pending_start busy=%b required 1", busy);
    end
    wait_idle();
    vectors++;
    if (rf[3] !== 16'd5 || retired !== 16'd6) begin
      miscompares++;
      $display("FAIL halt_pending_result r3=%0d retired=%0d required 5 6", rf[3], retired);
    end
    $display("test_halt_resume r3=%0d retired=%0d", rf[3], retired);
  endtask

  task automatic test_self_overwrite;
    send(mk(OP_NOT, 3'd4, 3'd0, 3'd0, 3'd0));
    wait_idle();
    vectors++;
    if (rf[4] !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL self_setup r4=%h required ffff", rf[4]);
    end
    send(mk(OP_ADDI, 3'd4, 3'd4, 3'd0, 3'd7));
    tick();
    vectors++;
    if (FS !== 4'h8 || MB !== 1'b1 || ConstantIn !== 16'd7) begin
      miscompares++;
      $display("FAIL addi_exec_ctrl fs=%h mb=%b const=%h required 8 1 0007", FS, MB, ConstantIn);
    end
    wait_idle();
    vectors++;
    if (rf[4] !== 16'h0006 || retired !== 16'd8) begin
      miscompares++;
      $display("FAIL addi_self r4=%h retired=%0d required 0006 8", rf[4], retired);
    end
    $display("test_self_overwrite r4=%h retired=%0d", rf[4], retired);
  endtask

  task automatic test_reset_mid;
    send(mk(OP_ADD, 3'd5, 3'd1, 3'd1, 3'd0));
    tick();
    tick();
    vectors++;
    if (ReadOrWrite !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_in_wb row=%b required 1", ReadOrWrite);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (ReadOrWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_row_drop row=%b required 0", ReadOrWrite);
    end
    tick();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || halted !== 1'b0 || retired !== 16'd0 || ibus.instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_state busy=%b halted=%b retired=%0d ready=%b required 0 0 0 1",
               busy, halted, retired, ibus.instr_ready);
    end
    tick();
    vectors++;
    if (ReadOrWrite !== 1'b0 || ibus.instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_after row=%b ready=%b required 0 1", ReadOrWrite, ibus.instr_ready);
    end
    $display("test_reset_mid retired=%0d", retired);
  endtask

  task automatic test_counter_wrap;
    int         n;
    logic [1:0] exp_cnt;
    for (int i = 0; i < 6; i++) begin
      ibus2.instr = mk(OP_LDI, 3'd1, 3'd0, 3'd0, 3'(i));
      ibus2.instr_valid = 1'b1;
      n = 0;
      while (!ibus2.instr_ready && n < 50) begin
        tick();
        n++;
      end
      tick();
      ibus2.instr_valid = 1'b0;
      while (busy_w && n < 100) begin
        tick();
        n++;
      end
      exp_cnt = 2'(i + 1);
      vectors++;
      if (n >= 50 || retired_w !== exp_cnt) begin
        miscompares++;
        $display("FAIL wrap_count instr=%0d retired=%0d required %0d (wait=%0d)", i, retired_w, exp_cnt, n);
      end
      $display("test_counter_wrap instr=%0d retired=%0d", i, retired_w);
    end
  endtask

  initial begin
    ibus.instr = 16'h0000;
    ibus.instr_valid = 1'b0;
    ibus2.instr = 16'h0000;
    ibus2.instr_valid = 1'b0;
    test_reset();
    test_ldi_sequence();
    test_back_to_back();
    test_nop_illegal();
    test_halt_resume();
    test_self_overwrite();
    test_reset_mid();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
